add8_seq_ctrl: RTL and testbench

//   Sequencer that runs one shared 8-bit ripple adder (A,B,CI -> S,CO) as a multi-byte adder.

---
 rtl/add8_seq_ctrl_if.sv | 27 ++
 rtl/add8_seq_ctrl.sv | 116 +++++++++++
 tb/tb_add8_seq_ctrl.sv | 193 +++++++++++++++++++
 3 files changed

// File: rtl/add8_seq_ctrl_if.sv
// Operand/result bus of the multi-byte adder sequencer.
// Optional `sub` request bit is present when ADD8_SEQ_SUB_EN is defined.
interface add8_seq_ctrl_if #(
  parameter int NBYTES = 4
);
  localparam int W = 8 * NBYTES;

  logic         start;
  logic [W-1:0] op_a;
  logic [W-1:0] op_b;
  logic         cin;
`ifdef ADD8_SEQ_SUB_EN
  logic         sub;
`endif
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;

`ifdef ADD8_SEQ_SUB_EN
  modport master (output start, op_a, op_b, cin, sub, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, sub, output busy, done, sum, cout);
`else
  modport master (output start, op_a, op_b, cin, input busy, done, sum, cout);
  modport slave  (input start, op_a, op_b, cin, output busy, done, sum, cout);
`endif
endinterface

// File: rtl/add8_seq_ctrl.sv
// Runs an external 8-bit combinational adder as an NBYTES-wide adder, one byte per cycle, LSB first.
// Define ADD8_SEQ_SUB_EN to add the `sub` request bit (A-B via inverted B and forced carry-in).
module add8_seq_ctrl #(
  parameter int NBYTES = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  add8_seq_ctrl_if.slave       bus,
  output logic [7:0]           add_a,
  output logic [7:0]           add_b,
  output logic                 add_ci,
  input  logic [7:0]           add_s,
  input  logic                 add_co
);
  localparam int W  = 8 * NBYTES;
  localparam int IW = $clog2(NBYTES);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t        state, next_state;
  logic [W-1:0]  a_q, b_q, acc, sum_q;
  logic          cin_q, carry, cout_q;
  logic [IW-1:0] idx;
  logic          last;
  logic [7:0]    b_byte;
  logic          ci0;

  assign last = (idx == IW'(NBYTES - 1));

`ifdef ADD8_SEQ_SUB_EN
  logic sub_q;
  // Two's-complement subtract: invert B and inject the +1 through byte-0 carry.
  assign b_byte = b_q[8*idx +: 8] ^ {8{sub_q}};
  assign ci0    = sub_q ? 1'b1 : cin_q;
`else
  assign b_byte = b_q[8*idx +: 8];
  assign ci0    = cin_q;
`endif

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    next_state = state;
    bus.busy   = 1'b0;
    bus.done   = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_ci     = 1'b0;
    case (state)
      IDLE: if (bus.start) next_state = RUN;
      RUN: begin
        bus.busy = 1'b1;
        add_a    = a_q[8*idx +: 8];
        add_b    = b_byte;
        add_ci   = (idx == '0) ? ci0 : carry;
        if (last) next_state = DONE;
      end
      DONE: begin
        bus.busy   = 1'b1;
        bus.done   = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  // NOTE: the operand and accumulator registers are reset too, so an aborted run leaves no stale bytes.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      acc    <= '0;
      carry  <= 1'b0;
      idx    <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
`ifdef ADD8_SEQ_SUB_EN
      sub_q  <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          a_q   <= bus.op_a;
          b_q   <= bus.op_b;
          cin_q <= bus.cin;
          idx   <= '0;
          carry <= 1'b0;
`ifdef ADD8_SEQ_SUB_EN
          sub_q <= bus.sub;
`endif
        end
        RUN: begin
          acc[8*idx +: 8] <= add_s;
          carry           <= add_co;
          if (last) begin
            // Top byte is written to acc on this same edge, so splice it in directly.
            sum_q  <= {add_s, acc[W-9:0]};
            cout_q <= add_co;
          end else begin
            idx <= idx + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.sum  = sum_q;
  assign bus.cout = cout_q;
endmodule

// File: tb/tb_add8_seq_ctrl.sv
// Scoreboard bench for add8_seq_ctrl (NBYTES=4) with a behavioural 8-bit adder on the adder port.
module tb_add8_seq_ctrl;
  localparam int NBYTES = 4;
  localparam int W = 8 * NBYTES;

  typedef struct {
    logic [W-1:0] sum;
    logic         cout;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [7:0] add_a, add_b, add_s;
  logic add_ci, add_co;

  add8_seq_ctrl_if #(.NBYTES(NBYTES)) bus ();

  add8_seq_ctrl #(.NBYTES(NBYTES)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .add_a (add_a),
    .add_b (add_b),
    .add_ci(add_ci),
    .add_s (add_s),
    .add_co(add_co)
  );

  assign {add_co, add_s} = {1'b0, add_a} + {1'b0, add_b} + {8'd0, add_ci};

  always #5 clk = ~clk;

  int   tests = 0;
  int   fails = 0;
  int   done_count = 0;
  exp_t sb_q[$];
  logic [7:0] a_log [8];
  logic       ci_log[8];

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  // Monitor: each done pulse is matched against the oldest queued expectation.
  always @(negedge clk) begin
    if (rst_n && bus.done) begin
      exp_t e;
      done_count++;
      if (sb_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL sb_unexpected_done: got done=1 expected no result pending");
      end else begin
        e = sb_q.pop_front();
        check("sum", 64'(bus.sum), 64'(e.sum));
        check("cout", 64'(bus.cout), 64'(e.cout));
      end
    end
  end

  // Issues one operation; optionally pulses start at RUN cycle pulse_at or resets at RUN cycle reset_at.
  task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic ci,
                        input logic sb, input int pulse_at, input int reset_at, output int lat);
    @(negedge clk);
    bus.start = 1'b1;
    bus.op_a  = a;
    bus.op_b  = b;
    bus.cin   = ci;
`ifdef ADD8_SEQ_SUB_EN
    bus.sub   = sb;
`else
    if (sb) $display("note: sub requested but not built in");
`endif
    @(posedge clk);
    #1 bus.start = 1'b0;
    lat = 0;
    forever begin
      @(negedge clk);
      lat++;
      if (lat < 8) begin
        a_log[lat]  = add_a;
        ci_log[lat] = add_ci;
      end
      if (lat == pulse_at) begin
        bus.start = 1'b1;
        bus.op_a  = 32'h5555_5555;
        bus.op_b  = 32'h0F0F_0F0F;
      end else if (lat == pulse_at + 1) begin
        bus.start = 1'b0;
      end
      if (lat == reset_at) begin
        rst_n = 1'b0;
        #1;
        check("abort_busy", 64'(bus.busy), 0);
        check("abort_done", 64'(bus.done), 0);
        check("abort_sum", 64'(bus.sum), 0);
        check("abort_cout", 64'(bus.cout), 0);
        check("abort_add_a", 64'(add_a), 0);
        check("abort_add_b", 64'(add_b), 0);
        check("abort_add_ci", 64'(add_ci), 0);
        @(negedge clk);
        rst_n = 1'b1;
        break;
      end
      if (bus.done) break;
      if (lat > 20) begin
        check("done_timeout", 64'(lat), 64'(NBYTES + 1));
        break;
      end
    end
    @(negedge clk);
  endtask

  initial begin
    int lat;
    int dc;
    bus.start = 1'b0;
    bus.op_a  = '0;
    bus.op_b  = '0;
    bus.cin   = 1'b0;
`ifdef ADD8_SEQ_SUB_EN
    bus.sub   = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("rst_busy", 64'(bus.busy), 0);
    check("rst_done", 64'(bus.done), 0);
    check("rst_sum", 64'(bus.sum), 0);
    check("rst_cout", 64'(bus.cout), 0);
    check("rst_add_a", 64'(add_a), 0);
    check("rst_add_b", 64'(add_b), 0);
    check("rst_add_ci", 64'(add_ci), 0);
    rst_n = 1'b1;

    // 1: byte-0 carry into byte 1, latency
    sb_q.push_back('{32'h0000_0100, 1'b0});
    run_op(32'h0000_00FF, 32'h0000_0001, 1'b0, 1'b0, -10, -10, lat);
    check("t1_latency", 64'(lat), 5);

    // 2: full carry ripple, cout set
    sb_q.push_back('{32'h0000_0000, 1'b1});
    run_op(32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 1'b0, -10, -10, lat);
    check("t2_add_ci_seq", 64'({ci_log[1], ci_log[2], ci_log[3], ci_log[4]}), 64'(4'b0111));

    // 3: cin=1, byte order LSB first
    sb_q.push_back('{32'h2345_678A, 1'b0});
    run_op(32'h1234_5678, 32'h1111_1111, 1'b1, 1'b0, -10, -10, lat);
    check("t3_add_a_seq", 64'({a_log[1], a_log[2], a_log[3], a_log[4]}), 64'(32'h7856_3412));
    check("t3_add_ci_first", 64'(ci_log[1]), 1);

    // 4: start pulsed with new operands mid-RUN is ignored
    dc = done_count;
    sb_q.push_back('{32'h0000_3000, 1'b0});
    run_op(32'h0000_1000, 32'h0000_2000, 1'b0, 1'b0, 2, -10, lat);
    repeat (8) @(negedge clk);
    check("t4_done_pulses", 64'(done_count - dc), 1);
    check("t4_idle", 64'(bus.busy), 0);
    check("t4_sum_hold", 64'(bus.sum), 64'(32'h0000_3000));

    // 5: reset at RUN idx=2 aborts, then a normal run completes
    dc = done_count;
    run_op(32'h0101_0101, 32'h0202_0202, 1'b0, 1'b0, -10, 3, lat);
    repeat (8) @(negedge clk);
    check("t5_no_done", 64'(done_count - dc), 0);
    sb_q.push_back('{32'hBBCC_DDEE, 1'b0});
    run_op(32'hAABB_CCDD, 32'h1111_1111, 1'b0, 1'b0, -10, -10, lat);
    check("t5_latency", 64'(lat), 5);
    sb_q.push_back('{32'h0000_0000, 1'b1});
    run_op(32'hDEAD_BEEF, 32'h2152_4110, 1'b1, 1'b0, -10, -10, lat);

`ifdef ADD8_SEQ_SUB_EN
    // 6: subtract, borrow and no-borrow
    sb_q.push_back('{32'hFFFF_FFFE, 1'b0});
    run_op(32'h0000_0005, 32'h0000_0007, 1'b0, 1'b1, -10, -10, lat);
    sb_q.push_back('{32'h0000_0002, 1'b1});
    run_op(32'h0000_0007, 32'h0000_0005, 1'b0, 1'b1, -10, -10, lat);
`endif

    repeat (4) @(negedge clk);
    check("sb_drained", 64'(sb_q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: got no finish expected finish before 100000");
    $fatal(1, "timeout");
  end
endmodule
